// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between instruction fetch (I)
// and the data stage (D), with cancellation of fetches squashed by a taken branch.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;   // 1 = D owns the access
  logic          last_q, last_d;     // 1 = last grant went to D
  logic          drop_q, drop_d;
  logic          if_done_q, if_done_d, d_done_q, d_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic i_valid, grant_d, grant_i, last_cnt;

  // A fetch flushed in the same cycle it is presented is already stale.
  assign i_valid  = if_req && !if_flush;
  assign grant_d  = d_req && (!i_valid || !last_q);
  assign grant_i  = i_valid && !grant_d;
  assign last_cnt = (cnt_q == CW'(LATENCY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      drop_q      <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      drop_q      <= drop_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_i || grant_d) state_d = BUSY;
      BUSY:    if (last_cnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drop_d      = drop_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          mem_en_d    = 1'b1;
          mem_we_d    = grant_d && d_we;
          mem_addr_d  = grant_d ? d_addr : if_addr;
          mem_wdata_d = grant_d ? d_wdata : '0;
          cnt_d       = '0;
          owner_d     = grant_d;
          last_d      = grant_d;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (!owner_q && if_flush) drop_d = 1'b1;
        if (last_cnt) begin
          cnt_d    = '0;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_we_q ? '0 : mem_rdata;
          end else if (!drop_q && !if_flush) begin
            // The access still runs to completion after a flush; only the result is discarded.
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      DONE:    drop_d = 1'b0;
      default: ;
    endcase
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_done, d_req, d_we, d_done;
  logic        mem_en, mem_we;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ir, exp_dr;

  mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    exp_ir = 0; exp_dr = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    checks++;
    if ({if_done, d_done, mem_en, mem_we} !== 4'b0 || if_rdata !== 16'h0 || d_rdata !== 16'h0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got done=%b/%b en=%b we=%b addr=%h wdata=%h ir=%h dr=%h, want all 0",
               if_done, d_done, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst_n = 1;
    exp_ir = 0; exp_dr = 0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 16'h0010;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 5) exp_ir = 16'hA5A5;
      checks++;
      if (mem_en !== (c >= 1 && c <= 4)) begin
        failures++; $display("FAIL fetch_en c%0d: got %b", c, mem_en);
      end
      if (c <= 4) begin
        checks++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
          failures++; $display("FAIL fetch_addr c%0d: got %h we=%b want 0010 we=0", c, mem_addr, mem_we);
        end
      end
      checks++;
      if (if_done !== (c == 5) || d_done !== 1'b0) begin
        failures++; $display("FAIL fetch_done c%0d: got if_done=%b d_done=%b", c, if_done, d_done);
      end
      checks++;
      if (if_rdata !== exp_ir) begin
        failures++; $display("FAIL fetch_rdata c%0d: got %h want %h", c, if_rdata, exp_ir);
      end
      mem_rdata = (c == 4) ? 16'hA5A5 : 16'h0;
      if (c == 5) if_req = 0;
    end
  endtask

  task automatic test_tie_after_reset();
    logic [15:0] ea;
    do_reset();
    if_req = 1; if_addr = 16'h0020;
    d_req = 1; d_we = 0; d_addr = 16'h0100;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 5) exp_dr = 16'h1111;
      if (c == 11) exp_ir = 16'h2222;
      ea = (c <= 4) ? 16'h0100 : 16'h0020;
      checks++;
      if (mem_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
        failures++; $display("FAIL tie_en c%0d: got %b", c, mem_en);
      end
      if (mem_en === 1'b1) begin
        checks++;
        if (mem_addr !== ea || mem_we !== 1'b0) begin
          failures++; $display("FAIL tie_addr c%0d: got %h want %h", c, mem_addr, ea);
        end
      end
      checks++;
      if (d_done !== (c == 5) || if_done !== (c == 11)) begin
        failures++; $display("FAIL tie_done c%0d: got d=%b i=%b", c, d_done, if_done);
      end
      checks++;
      if (d_rdata !== exp_dr || if_rdata !== exp_ir) begin
        failures++; $display("FAIL tie_rdata c%0d: got d=%h i=%h want d=%h i=%h", c, d_rdata, if_rdata, exp_dr, exp_ir);
      end
      mem_rdata = (c == 4) ? 16'h1111 : (c == 10) ? 16'h2222 : 16'h0;
      if (c == 5) d_req = 0;
      if (c == 11) if_req = 0;
    end
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    mem_rdata = 16'hFFFF;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 5) exp_dr = 16'h0000;
      checks++;
      if (mem_en !== (c <= 4) || mem_we !== (c <= 4)) begin
        failures++; $display("FAIL store_en c%0d: got en=%b we=%b", c, mem_en, mem_we);
      end
      if (c <= 4) begin
        checks++;
        if (mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
          failures++; $display("FAIL store_data c%0d: got %h/%h want 0200/1234", c, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (d_done !== (c == 5) || if_done !== 1'b0 || d_rdata !== exp_dr) begin
        failures++; $display("FAIL store_done c%0d: got done=%b rdata=%h want rdata=%h", c, d_done, d_rdata, exp_dr);
      end
      if (c == 5) begin d_req = 0; d_we = 0; end
    end
    mem_rdata = 0;
  endtask

  task automatic test_flush();
    logic [15:0] ea;
    if_req = 1; if_addr = 16'h0030;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 11) exp_ir = 16'h5555;
      ea = (c <= 4) ? 16'h0030 : 16'h0040;
      checks++;
      if (mem_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
        failures++; $display("FAIL flush_en c%0d: got %b", c, mem_en);
      end
      if (mem_en === 1'b1) begin
        checks++;
        if (mem_addr !== ea) begin
          failures++; $display("FAIL flush_addr c%0d: got %h want %h", c, mem_addr, ea);
        end
      end
      checks++;
      if (if_done !== (c == 11) || if_rdata !== exp_ir) begin
        failures++; $display("FAIL flush_done c%0d: got done=%b rdata=%h want rdata=%h", c, if_done, if_rdata, exp_ir);
      end
      if_flush = (c == 2);
      if (c == 2) if_req = 0;
      if (c == 3) begin if_req = 1; if_addr = 16'h0040; end
      mem_rdata = (c == 4) ? 16'hDEAD : (c == 10) ? 16'h5555 : 16'h0;
      if (c == 11) if_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 16'h0050;
    step(); step(); step();
    checks++;
    if (mem_en !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: got en=%b want 1", mem_en);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({if_done, d_done, mem_en, mem_we} !== 4'b0 || mem_addr !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      failures++; $display("FAIL rstmid_async: got en=%b addr=%h ir=%h dr=%h want 0", mem_en, mem_addr, if_rdata, d_rdata);
    end
    if_req = 0; exp_ir = 0; exp_dr = 0;
    step(); step();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (if_done !== 1'b0 || d_done !== 1'b0 || mem_en !== 1'b0) begin
        failures++; $display("FAIL rstmid_quiet c%0d: got done=%b/%b en=%b", c, if_done, d_done, mem_en);
      end
    end
    if_req = 1; if_addr = 16'h0060;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 5) exp_ir = 16'h7777;
      checks++;
      if (mem_en !== (c <= 4) || if_done !== (c == 5) || if_rdata !== exp_ir) begin
        failures++; $display("FAIL rstmid_refetch c%0d: got en=%b done=%b rdata=%h want rdata=%h", c, mem_en, if_done, if_rdata, exp_ir);
      end
      if (c <= 4) begin
        checks++;
        if (mem_addr !== 16'h0060) begin
          failures++; $display("FAIL rstmid_addr c%0d: got %h want 0060", c, mem_addr);
        end
      end
      mem_rdata = (c == 4) ? 16'h7777 : 16'h0;
      if (c == 5) if_req = 0;
    end
  endtask

  task automatic test_back_to_back();
    int k, p;
    bit own_d;
    do_reset();
    if_req = 1; if_addr = 16'h0070;
    d_req = 1; d_we = 0; d_addr = 16'h0080;
    for (int c = 1; c <= 24; c++) begin
      step();
      k = (c - 1) / 6;
      p = (c - 1) % 6 + 1;
      own_d = (k % 2 == 0);
      if (p == 5 && own_d) exp_dr = 16'h1000 + 16'(c - 1);
      if (p == 5 && !own_d) exp_ir = 16'h1000 + 16'(c - 1);
      checks++;
      if (mem_en !== (p <= 4)) begin
        failures++; $display("FAIL b2b_en c%0d: got %b", c, mem_en);
      end
      if (p <= 4) begin
        checks++;
        if (mem_addr !== (own_d ? 16'h0080 : 16'h0070)) begin
          failures++; $display("FAIL b2b_owner c%0d: got addr %h want %h", c, mem_addr, own_d ? 16'h0080 : 16'h0070);
        end
      end
      checks++;
      if (d_done !== (p == 5 && own_d) || if_done !== (p == 5 && !own_d)) begin
        failures++; $display("FAIL b2b_done c%0d: got d=%b i=%b", c, d_done, if_done);
      end
      checks++;
      if (d_rdata !== exp_dr || if_rdata !== exp_ir) begin
        failures++; $display("FAIL b2b_rdata c%0d: got d=%h i=%h want d=%h i=%h", c, d_rdata, if_rdata, exp_dr, exp_ir);
      end
      mem_rdata = 16'h1000 + 16'(c);
      if (c == 24) begin if_req = 0; d_req = 0; end
    end
    step();
  endtask

  // Reference model: one outstanding transaction described by its grant cycle g;
  // every observable is a function of (c - g) and the owner.
  task automatic test_random();
    int g = 0;
    bit act = 0, own_d = 0, drop = 0, last_d = 0, m_we = 0;
    bit ip = 0, dp = 0, dwe = 0;
    bit en_e, id_e, dd_e, gd, ie;
    logic [15:0] m_addr = 0, m_wdata = 0, cap = 0, ia = 0, da = 0, dwd = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) step();
      en_e = act && c >= g + 1 && c <= g + L;
      id_e = act && !own_d && !drop && c == g + L + 1;
      dd_e = act && own_d && c == g + L + 1;
      if (id_e) exp_ir = cap;
      if (dd_e) exp_dr = m_we ? 16'h0 : cap;
      checks++;
      if (mem_en !== en_e || if_done !== id_e || d_done !== dd_e) begin
        failures++; $display("FAIL rnd_ctrl c%0d: got en=%b i=%b d=%b want en=%b i=%b d=%b",
                             c, mem_en, if_done, d_done, en_e, id_e, dd_e);
      end
      if (en_e) begin
        checks++;
        if (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wdata)) begin
          failures++; $display("FAIL rnd_access c%0d: got %h we=%b wd=%h want %h we=%b wd=%h",
                               c, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
        end
      end
      checks++;
      if (if_rdata !== exp_ir || d_rdata !== exp_dr) begin
        failures++; $display("FAIL rnd_rdata c%0d: got i=%h d=%h want i=%h d=%h", c, if_rdata, d_rdata, exp_ir, exp_dr);
      end
      if (id_e) ip = 0;
      if (dd_e) dp = 0;
      if_flush = 0;
      if (ip && $urandom_range(7) == 0) begin
        if_flush = 1; ip = 0;
      end else if (!ip && $urandom_range(2) == 0) begin
        ip = 1; ia = 16'($urandom);
      end
      if_req = ip || if_flush;
      if_addr = ia;
      if (!dp && $urandom_range(3) == 0) begin
        dp = 1; dwe = 1'($urandom); da = 16'($urandom); dwd = 16'($urandom);
      end
      d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd;
      mem_rdata = 16'($urandom);
      if (act && !own_d && if_flush && c >= g + 1 && c <= g + L) drop = 1;
      if (act && c == g + L) cap = mem_rdata;
      if (!act || c >= g + L + 2) begin
        act = 0;
        ie = if_req && !if_flush;
        if (ie || d_req) begin
          gd = d_req && (!ie || !last_d);
          act = 1; g = c; own_d = gd; last_d = gd; drop = 0;
          m_we = gd && dwe;
          m_addr = gd ? da : ia;
          m_wdata = gd ? dwd : 16'h0;
        end
      end
    end
    idle_inputs();
    for (int i = 0; i < L + 3; i++) step();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    exp_ir = 0; exp_dr = 0;
    test_reset();
    test_fetch();
    test_tie_after_reset();
    test_store();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
